bcd_display_scan: RTL and testbench

//  Downstream consumer of the BCD ALU front-end. Captures the 36-bit packed-BCD

---
 rtl/bcd_display_scan_if.sv | 25 ++
 rtl/bcd_display_scan.sv | 166 ++++++++++++++++
 tb/tb_bcd_display_scan.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_scan_if.sv
// Bus bundle between the BCD ALU front-end (master) and the 7-segment scanner (slave):
// captured result/flags inward, multiplexed digit enables, segments and frame pulse outward.
interface bcd_display_scan_if #(
    parameter int NUM_DIGITS = 9
);
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   result;
    logic                      carry_out;
    logic                      overflow;
    logic                      zero;
    logic [NUM_DIGITS-1:0]     an;
    logic [6:0]                seg;
    logic                      dp;
    logic                      frame_done;

    modport master (
        output load, result, carry_out, overflow, zero,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  load, result, carry_out, overflow, zero,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/bcd_display_scan.sv
// Frame-synchronous scanner driving a packed-BCD result onto a common-anode 7-segment display.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant nonzero digit.
module bcd_display_scan #(
    parameter int NUM_DIGITS  = 9,
    parameter int REFRESH_DIV = 50000
) (
    input logic               clk,
    input logic               rst_n,
    bcd_display_scan_if.slave bus
);
    localparam int RW = 4 * NUM_DIGITS;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {BLANK = 1'b0, SCAN = 1'b1} state_t;

    typedef struct packed {
        logic [RW-1:0] result;
        logic          carry;
        logic          ovf;
        logic          zero;
    } snap_t;

    function automatic logic [6:0] bcd_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'd0:    g = 7'h40;
            4'd1:    g = 7'h79;
            4'd2:    g = 7'h24;
            4'd3:    g = 7'h30;
            4'd4:    g = 7'h19;
            4'd5:    g = 7'h12;
            4'd6:    g = 7'h02;
            4'd7:    g = 7'h78;
            4'd8:    g = 7'h00;
            4'd9:    g = 7'h10;
            default: g = 7'h3F;
        endcase
        return g;
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    // Invalid nibbles count as significant so they are never blanked away.
    function automatic logic [IW-1:0] msd_index(input logic [RW-1:0] r);
        logic [IW-1:0] m;
        m = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            m = (r[4*k +: 4] != 4'd0) ? IW'(k) : m;
        end
        return m;
    endfunction
`endif

    state_t                state_r;
    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    snap_t                 shadow_r;
    snap_t                 active_r;
    logic [NUM_DIGITS-1:0] an_r;
    logic [6:0]            seg_r;
    logic                  dp_r;
    logic                  frame_done_r;

    snap_t                 incoming_s;
    logic [3:0]            digit_s;
    logic                  blank_s;
    logic [6:0]            glyph_s;
    logic                  dp_s;
    logic [NUM_DIGITS-1:0] an_s;

    assign incoming_s = '{result: bus.result, carry: bus.carry_out,
                          ovf: bus.overflow, zero: bus.zero};

    // Glyph, decimal point and enable pattern for the digit currently indexed
    always_comb begin
        digit_s = 4'd0;
        an_s    = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            digit_s  = digit_s | ((idx_r == IW'(k)) ? active_r.result[4*k +: 4] : 4'd0);
            an_s[k]  = (idx_r == IW'(k)) ? 1'b0 : 1'b1;
        end
`ifdef LEADING_ZERO_BLANK_EN
        blank_s = (idx_r > msd_index(active_r.result));
`else
        blank_s = 1'b0;
`endif
        if (active_r.ovf) begin
            glyph_s = 7'h06;
        end else if (blank_s) begin
            glyph_s = 7'h7F;
        end else begin
            glyph_s = bcd_glyph(digit_s);
        end
        if (active_r.ovf) begin
            dp_s = 1'b1;
        end else if ((idx_r == IDX_LAST) && active_r.carry) begin
            dp_s = 1'b0;
        end else if ((idx_r == '0) && active_r.zero) begin
            dp_s = 1'b0;
        end else begin
            dp_s = 1'b1;
        end
    end

    // Scan FSM, shadow/active capture and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= BLANK;
            cnt_r        <= '0;
            idx_r        <= '0;
            shadow_r     <= '0;
            active_r     <= '0;
            an_r         <= '1;
            seg_r        <= 7'h7F;
            dp_r         <= 1'b1;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                BLANK: begin
                    an_r  <= '1;
                    seg_r <= 7'h7F;
                    dp_r  <= 1'b1;
                    if (bus.load) begin
                        state_r  <= SCAN;
                        shadow_r <= incoming_s;
                        active_r <= incoming_s;
                        cnt_r    <= '0;
                        idx_r    <= '0;
                    end
                end
                SCAN: begin
                    an_r  <= an_s;
                    seg_r <= glyph_s;
                    dp_r  <= dp_s;
                    if (bus.load) begin
                        shadow_r <= incoming_s;
                    end
                    if (cnt_r == CNT_LAST) begin
                        cnt_r <= '0;
                        if (idx_r == IDX_LAST) begin
                            // Frame wrap: a coincident load bypasses the shadow copy.
                            idx_r        <= '0;
                            frame_done_r <= 1'b1;
                            active_r     <= bus.load ? incoming_s : shadow_r;
                        end else begin
                            idx_r <= idx_r + IW'(1);
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= BLANK;
                end
            endcase
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_bcd_display_scan.sv
// Bench for bcd_display_scan: frame-level model checked every cycle, plus hand-computed glyph pins.
module tb_bcd_display_scan;
    localparam int N   = 9;
    localparam int DIV = 4;
    localparam int F   = N * DIV;

    typedef struct packed {
        logic [35:0] r;
        logic        c;
        logic        o;
        logic        z;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    bcd_display_scan_if #(.NUM_DIGITS(N)) bus();

    bcd_display_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] LEAD0 = 7'h7F;
`else
    localparam logic [6:0] LEAD0 = 7'h40;
`endif

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] model_seg(input snap_t s, input int d);
        int nib;
        int msd;
        if (s.o) return 7'h06;
        nib = int'((s.r >> (4 * d)) & 36'hF);
        msd = 0;
        for (int k = 0; k < N; k++) begin
            if (((s.r >> (4 * k)) & 36'hF) != 36'h0) msd = k;
        end
`ifdef LEADING_ZERO_BLANK_EN
        if (d > msd) return 7'h7F;
`endif
        if (nib > 9) return 7'h3F;
        return glyph_tab[nib];
    endfunction

    function automatic logic model_dp(input snap_t s, input int d);
        if (s.o) return 1'b1;
        if (d == N - 1 && s.c) return 1'b0;
        if (d == 0 && s.z) return 1'b0;
        return 1'b1;
    endfunction

    // Frame model: n counts clock edges since scanning began; frames hold one value each
    logic  m_scan = 1'b0;
    int    m_n = 0;
    snap_t m_frame = '0;
    snap_t m_pend = '0;
    snap_t m_shown = '0;
    snap_t cap_s;
    assign cap_s = '{r: bus.result, c: bus.carry_out, o: bus.overflow, z: bus.zero};

    always @(posedge clk) begin
        if (!rst_n) begin
            m_scan <= 1'b0;
            m_n    <= 0;
        end else if (!m_scan) begin
            m_shown <= m_frame;
            if (bus.load) begin
                m_scan  <= 1'b1;
                m_n     <= 0;
                m_frame <= cap_s;
                m_pend  <= cap_s;
            end
        end else begin
            m_shown <= m_frame;
            m_n     <= m_n + 1;
            if (bus.load) m_pend <= cap_s;
            if ((m_n + 1) % F == 0) m_frame <= bus.load ? cap_s : m_pend;
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        logic [8:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_fd;
        int         s;
        int         d;
        if (!rst_n || !m_scan || m_n == 0) begin
            e_an = 9'h1FF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        end else begin
            s     = m_n - 1;
            d     = (s / DIV) % N;
            e_an  = ~(9'h001 << d);
            e_seg = model_seg(m_shown, d);
            e_dp  = model_dp(m_shown, d);
            e_fd  = (s % F == F - 1);
        end
        chk("an", 36'(bus.an), 36'(e_an));
        chk("seg", 36'(bus.seg), 36'(e_seg));
        chk("dp", 36'(bus.dp), 36'(e_dp));
        chk("frame_done", 36'(bus.frame_done), 36'(e_fd));
    end

    task automatic drive_load(input logic [35:0] r, input logic c, input logic o, input logic z);
        @(posedge clk); #2;
        bus.load = 1'b1; bus.result = r; bus.carry_out = c; bus.overflow = o; bus.zero = z;
        @(posedge clk); #2;
        bus.load = 1'b0;
        bus.result = 36'({$urandom(), $urandom()});
        bus.carry_out = 1'($urandom()); bus.overflow = 1'($urandom()); bus.zero = 1'($urandom());
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        #3;
    endtask

    task automatic lit(input string name, input logic [8:0] an, input logic [6:0] seg, input logic dp);
        chk({name, ".an"}, 36'(bus.an), 36'(an));
        chk({name, ".seg"}, 36'(bus.seg), 36'(seg));
        chk({name, ".dp"}, 36'(bus.dp), 36'(dp));
    endtask

    task automatic wait_fd();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            wait_edges(1);
            seen = bus.frame_done;
        end
        n_cmp++;
        if (!seen) begin
            n_fail++;
            $display("FAIL frame_done_timeout at %0t: got none in 100 cycles, expected a pulse", $time);
        end
    endtask

    initial begin
        bus.load = 1'b0; bus.result = '0; bus.carry_out = 1'b0; bus.overflow = 1'b0; bus.zero = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        wait_edges(100);
        lit("idle", 9'h1FF, 7'h7F, 1'b1);

        drive_load(36'h000000123, 1'b0, 1'b0, 1'b0);
        wait_edges(1);  lit("d0_3", 9'h1FE, 7'h30, 1'b1);
        wait_edges(4);  lit("d1_2", 9'h1FD, 7'h24, 1'b1);
        wait_edges(4);  lit("d2_1", 9'h1FB, 7'h79, 1'b1);
        wait_edges(4);  lit("d3_lead", 9'h1F7, LEAD0, 1'b1);
        wait_edges(23);
        chk("fd_first", 36'(bus.frame_done), 36'h1);
        chk("fd_first.an", 36'(bus.an), 36'h0FF);

        wait_fd();
        wait_edges(2);
        drive_load(36'h000000042, 1'b0, 1'b0, 1'b0);
        drive_load(36'h000000099, 1'b0, 1'b0, 1'b0);
        wait_edges(3);  lit("old_frame_d2", 9'h1FB, 7'h79, 1'b1);
        wait_fd();
        wait_edges(1);  lit("new_d0_9", 9'h1FE, 7'h10, 1'b1);
        wait_edges(4);  lit("new_d1_9", 9'h1FD, 7'h10, 1'b1);
        wait_edges(4);  lit("new_d2", 9'h1FB, LEAD0, 1'b1);

        drive_load(36'h987654321, 1'b1, 1'b1, 1'b1);
        wait_fd();
        wait_edges(1);  lit("ovf_d0", 9'h1FE, 7'h06, 1'b1);
        wait_edges(32); lit("ovf_d8", 9'h0FF, 7'h06, 1'b1);

        drive_load(36'h00000000C, 1'b1, 1'b0, 1'b1);
        wait_fd();
        wait_edges(1);  lit("inv_d0", 9'h1FE, 7'h3F, 1'b0);
        wait_edges(32); lit("carry_d8", 9'h0FF, LEAD0, 1'b0);

        drive_load(36'h000000123, 1'b0, 1'b0, 1'b0);
        wait_fd();
        wait_edges(21); lit("pre_reset_d5", 9'h1DF, LEAD0, 1'b1);
        rst_n = 1'b0;
        #1 lit("async_reset", 9'h1FF, 7'h7F, 1'b1);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_edges(20); lit("post_reset", 9'h1FF, 7'h7F, 1'b1);

        drive_load(36'h000000050, 1'b0, 1'b0, 1'b0);
        wait_edges(1);  lit("reload_d0", 9'h1FE, 7'h40, 1'b1);
        wait_edges(4);  lit("reload_d1", 9'h1FD, 7'h12, 1'b1);
        wait_edges(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
